// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access for byte/half/word loads and stores, plus the MEM/WB register.
// Latency: 1 cycle for non-memory or misaligned instructions; 3 cycles for an access acked in its first BUSY cycle.
// Backpressure: mem_stall holds the upstream pipeline from access start until the DONE cycle.
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_RFRD2,
  input  logic [31:0] mem_ALUOUT,
  input  logic [4:0]  mem_RegisterRd,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_RegWrite,
  input  logic        mem_call,
  input  logic [31:0] mem_pcplus4,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] wb_inst,
  output logic [4:0]  wb_RegisterRd,
  output logic        wb_RegWrite,
  output logic [31:0] wb_WData,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        abort_q;
  logic [31:0] rdata_q;
  logic [1:0]  off_q;

  logic [5:0]  opcode;
  logic        is_byte, is_half, is_unsigned;
  logic        access, aligned, misaligned, start;
  logic [31:0] wdata_n, load_data;
  logic [3:0]  be_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign opcode = mem_inst[31:26];

  // Unknown opcodes that still touch memory fall through to word size.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    case (opcode)
      6'h20, 6'h24, 6'h28: is_byte = 1'b1;
      6'h21, 6'h25, 6'h29: is_half = 1'b1;
      default: ;
    endcase
  end

  assign is_unsigned = (opcode == 6'h24) || (opcode == 6'h25);
  assign access      = mem_MemRead | mem_MemWrite;
  assign aligned     = is_byte | (is_half ? ~mem_ALUOUT[0] : (mem_ALUOUT[1:0] == 2'b00));
  assign misaligned  = access & ~aligned;
  assign start       = (state == IDLE) & access & aligned;
  assign mem_stall   = start | (state == BUSY);

  always_comb begin
    wdata_n = mem_RFRD2;
    be_n    = 4'b1111;
    if (is_byte) begin
      wdata_n = {4{mem_RFRD2[7:0]}};
      be_n    = 4'b0001 << mem_ALUOUT[1:0];
    end else if (is_half) begin
      wdata_n = {2{mem_RFRD2[15:0]}};
      be_n    = mem_ALUOUT[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign ld_byte = rdata_q[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    if (is_byte)
      load_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      abort_q  <= 1'b0;
      rdata_q  <= '0;
      off_q    <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_be    <= '0;
      mem_err  <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          mem_err <= misaligned;
          if (start) begin
            state    <= BUSY;
            wait_cnt <= '0;
            dm_req   <= 1'b1;
            dm_we    <= mem_MemWrite;
            dm_addr  <= {mem_ALUOUT[31:2], 2'b00};
            dm_wdata <= wdata_n;
            dm_be    <= be_n;
            off_q    <= mem_ALUOUT[1:0];
          end
        end
        BUSY: begin
          if (dm_ack) begin
            rdata_q <= dm_rdata;
            dm_req  <= 1'b0;
            state   <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            dm_req  <= 1'b0;
            mem_err <= 1'b1;
            abort_q <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          abort_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB: inputs are held during the stall, so DONE sees the same instruction that started the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_inst       <= '0;
      wb_RegisterRd <= '0;
      wb_RegWrite   <= 1'b0;
      wb_WData      <= '0;
    end else if (mem_stall) begin
      wb_inst       <= '0;
      wb_RegisterRd <= '0;
      wb_RegWrite   <= 1'b0;
      wb_WData      <= '0;
    end else begin
      wb_inst       <= mem_inst;
      wb_RegisterRd <= mem_RegisterRd;
      wb_RegWrite   <= mem_RegWrite & ~(misaligned | abort_q);
      wb_WData      <= mem_call ? mem_pcplus4 : (mem_MemtoReg ? load_data : mem_ALUOUT);
    end
  end

endmodule
